// File: rtl/tlul_arb2.sv
// Two-host TL-UL arbiter with round-robin grant, handshake locking and an
// in-order response-routing FIFO that steers device responses back to the issuer.
package tluh_32_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module tlul_arb2
    import tluh_32_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  tl_h2d_t                      tl_h0_i,
    output tl_d2h_t                      tl_h0_o,
    input  tl_h2d_t                      tl_h1_i,
    output tl_d2h_t                      tl_h1_o,
    output tl_h2d_t                      tl_d_o,
    input  tl_d2h_t                      tl_d_i,
    output logic [$clog2(Depth+1)-1:0]   outstanding_o,
    output logic                         unexp_rsp_o
);

    localparam int unsigned CW = $clog2(Depth + 1);
    localparam int unsigned PW = $clog2(Depth);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e           state_q, state_d;
    logic             rr_q;
    logic             win_q, win_d;
    logic             winner;
    logic [Depth-1:0] fifo_q;
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    cnt_q;
    logic             unexp_q;
    logic             full, empty, head_host;
    logic             dev_a_valid, dev_d_ready;
    logic             push, pop;
    tl_h2d_t          win_req;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (cnt_q == CW'(Depth));
    assign empty     = (cnt_q == '0);
    assign head_host = fifo_q[head_q];

    always_comb begin
        winner = win_q;
        if (state_q == IDLE) begin
            if (tl_h0_i.a_valid && tl_h1_i.a_valid) winner = rr_q;
            else                                    winner = tl_h1_i.a_valid;
        end
    end

    assign win_req     = winner ? tl_h1_i : tl_h0_i;
    assign dev_a_valid = win_req.a_valid & ~full & rst_ni;
    assign dev_d_ready = empty ? 1'b1 : (head_host ? tl_h1_i.d_ready : tl_h0_i.d_ready);
    assign push        = dev_a_valid & tl_d_i.a_ready;
    assign pop         = tl_d_i.d_valid & dev_d_ready & ~empty;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                if (dev_a_valid && !tl_d_i.a_ready) begin
                    state_d = LOCKED;
                    win_d   = winner;
                end
            end
            LOCKED: begin
                if (push) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            rr_q    <= 1'b0;
            fifo_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            unexp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            unexp_q <= tl_d_i.d_valid & empty;
            if (push) begin
                fifo_q[tail_q] <= winner;
                tail_q         <= ptr_inc(tail_q);
                rr_q           <= ~winner;
            end
            if (pop) head_q <= ptr_inc(head_q);
            // push is already blocked when full and pop when empty, so cnt_q stays in 0..Depth
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_comb begin
        tl_d_o          = win_req;
        tl_d_o.a_valid  = dev_a_valid;
        tl_d_o.d_ready  = dev_d_ready;

        tl_h0_o         = tl_d_i;
        tl_h0_o.a_ready = ~winner & tl_d_i.a_ready & ~full & rst_ni;
        tl_h0_o.d_valid = tl_d_i.d_valid & ~empty & ~head_host & rst_ni;

        tl_h1_o         = tl_d_i;
        tl_h1_o.a_ready = winner & tl_d_i.a_ready & ~full & rst_ni;
        tl_h1_o.d_valid = tl_d_i.d_valid & ~empty & head_host & rst_ni;
    end

    assign outstanding_o = cnt_q;
    assign unexp_rsp_o   = unexp_q;

endmodule

// File: tb/tb_tlul_arb2.sv
// Randomized bench for tlul_arb2 against a queue-based model of grant order
// and in-order response routing, with directed arbitration/reset scenarios.
module tb_tlul_arb2;
    import tluh_32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    tl_h2d_t     h0_i, h1_i, d_o;
    tl_d2h_t     h0_o, h1_o, d_i;
    logic [2:0]  outstanding;
    logic        unexp;

    int n_checks = 0;
    int n_fail   = 0;

    int q[$];
    int rr, lock;
    bit unexp_exp;
    bit last_acc;
    int last_win;

    always #5 clk = ~clk;

    tlul_arb2 #(.Depth(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .tl_h0_i       (h0_i),
        .tl_h0_o       (h0_o),
        .tl_h1_i       (h1_i),
        .tl_h1_o       (h1_o),
        .tl_d_o        (d_o),
        .tl_d_i        (d_i),
        .outstanding_o (outstanding),
        .unexp_rsp_o   (unexp)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rr        = 0;
        lock      = -1;
        unexp_exp = 1'b0;
    endtask

    function automatic tl_h2d_t make_req(input bit v, input bit dr);
        tl_h2d_t r;
        r           = '0;
        r.a_valid   = v;
        r.a_opcode  = 3'($urandom_range(0, 4));
        r.a_size    = 2'($urandom_range(0, 2));
        r.a_source  = 8'($urandom);
        r.a_address = $urandom;
        r.a_mask    = 4'($urandom);
        r.a_data    = $urandom;
        r.d_ready   = dr;
        return r;
    endfunction

    // Called at a falling edge with inputs driven; returns at the next falling edge.
    task automatic cycle();
        int win, head;
        bit full, dav, dr_exp;
        #1;
        full = (q.size() == 4);
        head = (q.size() > 0) ? q[0] : -1;
        if (lock >= 0)                        win = lock;
        else if (h0_i.a_valid && h1_i.a_valid) win = rr;
        else                                  win = h1_i.a_valid ? 1 : 0;
        dav    = (win == 1 ? h1_i.a_valid : h0_i.a_valid) && !full;
        dr_exp = (head < 0) ? 1'b1 : (head == 1 ? h1_i.d_ready : h0_i.d_ready);

        check_eq("dev_a_valid", d_o.a_valid, dav);
        if (dav) check_eq("dev_a_address", d_o.a_address, win == 1 ? h1_i.a_address : h0_i.a_address);
        check_eq("h0_a_ready", h0_o.a_ready, win == 0 && d_i.a_ready && !full);
        check_eq("h1_a_ready", h1_o.a_ready, win == 1 && d_i.a_ready && !full);
        check_eq("h0_d_valid", h0_o.d_valid, d_i.d_valid && head == 0);
        check_eq("h1_d_valid", h1_o.d_valid, d_i.d_valid && head == 1);
        if (head == 0 && d_i.d_valid) check_eq("h0_d_data", h0_o.d_data, d_i.d_data);
        if (head == 1 && d_i.d_valid) check_eq("h1_d_data", h1_o.d_data, d_i.d_data);
        check_eq("dev_d_ready", d_o.d_ready, dr_exp);
        check_eq("outstanding", outstanding, q.size());
        check_eq("unexp_rsp", unexp, unexp_exp);

        unexp_exp = d_i.d_valid && head < 0;
        if (d_i.d_valid && head >= 0 && dr_exp) void'(q.pop_front());
        last_acc = dav && d_i.a_ready;
        last_win = win;
        if (last_acc) begin
            q.push_back(win);
            rr   = 1 - win;
            lock = -1;
        end else if (dav) begin
            lock = win;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q.size() > 0 || lock >= 0); i++) begin
            h0_i.a_valid = (lock == 0);
            h1_i.a_valid = (lock == 1);
            h0_i.d_ready = 1'b1;
            h1_i.d_ready = 1'b1;
            d_i.a_ready  = 1'b1;
            d_i.d_valid  = (q.size() > 0);
            d_i.d_data   = $urandom;
            cycle();
        end
        check_eq("drain_done", q.size() + (lock >= 0 ? 1 : 0), 0);
        h0_i.a_valid = 1'b0;
        h1_i.a_valid = 1'b0;
        d_i.d_valid  = 1'b0;
        cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        h0_i  = make_req(1'b1, 1'b1);
        h1_i  = make_req(1'b1, 1'b1);
        d_i   = '0;
        d_i.a_ready = 1'b1;
        d_i.d_valid = 1'b1;
        model_reset();
        #3;
        check_eq("rst_dev_a_valid", d_o.a_valid, 0);
        check_eq("rst_h0_a_ready", h0_o.a_ready, 0);
        check_eq("rst_h1_a_ready", h1_o.a_ready, 0);
        check_eq("rst_h0_d_valid", h0_o.d_valid, 0);
        check_eq("rst_h1_d_valid", h1_o.d_valid, 0);
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_unexp", unexp, 0);
        d_i.d_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Both hosts request continuously: grants alternate until the FIFO fills.
        for (int i = 0; i < 4; i++) begin
            h0_i = make_req(1'b1, 1'b0);
            h1_i = make_req(1'b1, 1'b0);
            cycle();
            check_eq("alt_grant_acc", last_acc, 1);
            check_eq("alt_grant_win", last_win, i % 2);
        end
        cycle();
        check_eq("full_no_accept", last_acc, 0);
        // One response pops the head (h0); the next cycle accepts a request.
        d_i.d_valid = 1'b1;
        d_i.d_data  = $urandom;
        h0_i.d_ready = 1'b1;
        cycle();
        check_eq("full_pop_no_accept", last_acc, 0);
        d_i.d_valid = 1'b0;
        cycle();
        check_eq("after_pop_accept", last_acc, 1);
        drain();

        // Spurious response with an empty FIFO.
        d_i.d_valid = 1'b1;
        cycle();
        d_i.d_valid = 1'b0;
        cycle();
        check_eq("unexp_one_cycle", unexp, 0);

        // h1 locked during a device stall; h0 joins mid-stall.
        d_i.a_ready  = 1'b0;
        h1_i = make_req(1'b1, 1'b1);
        h0_i = make_req(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) h0_i.a_valid = 1'b1;
            cycle();
            check_eq("stall_win_h1", last_win, 1);
        end
        d_i.a_ready = 1'b1;
        cycle();
        check_eq("stall_acc_h1", last_acc && last_win == 1, 1);
        h1_i.a_valid = 1'b0;
        cycle();
        check_eq("stall_then_h0", last_acc && last_win == 0, 1);
        drain();

        // Randomized traffic; hosts hold a_valid until accepted.
        for (int c = 0; c < 3000; c++) begin
            d_i.a_ready  = ($urandom_range(0, 99) < 60);
            d_i.d_valid  = (q.size() > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 5);
            d_i.d_data   = $urandom;
            d_i.d_opcode = 3'($urandom);
            d_i.d_error  = 1'($urandom);
            h0_i.d_ready = ($urandom_range(0, 99) < 70);
            h1_i.d_ready = ($urandom_range(0, 99) < 70);
            cycle();
            if (last_acc && last_win == 0) h0_i = make_req($urandom_range(0, 99) < 50, h0_i.d_ready);
            else if (!h0_i.a_valid)        h0_i = make_req($urandom_range(0, 99) < 40, h0_i.d_ready);
            if (last_acc && last_win == 1) h1_i = make_req($urandom_range(0, 99) < 50, h1_i.d_ready);
            else if (!h1_i.a_valid)        h1_i = make_req($urandom_range(0, 99) < 40, h1_i.d_ready);
        end
        drain();

        // Reset with two requests outstanding.
        d_i.a_ready = 1'b1;
        h0_i = make_req(1'b1, 1'b0);
        h1_i = make_req(1'b1, 1'b0);
        cycle();
        cycle();
        check_eq("pre_reset_outstanding", outstanding, 2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_outstanding", outstanding, 0);
        check_eq("async_rst_a_valid", d_o.a_valid, 0);
        check_eq("async_rst_h0_a_ready", h0_o.a_ready, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check_eq("post_reset_grant_h0", last_acc && last_win == 0, 1);
        h0_i.a_valid = 1'b0;
        h1_i.a_valid = 1'b0;
        d_i.d_valid  = 1'b1;
        h0_i.d_ready = 1'b1;
        h1_i.d_ready = 1'b1;
        cycle();
        d_i.d_valid = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
